lipsi_prog_loader: RTL and testbench

//  Upstream stage of lipsi_processor. Receives a framed program over a byte stream (valid/ready),

---
 rtl/lipsi_prog_loader_if.sv | 8 +
 rtl/lipsi_prog_loader.sv | 141 ++++++++++++++
 tb/tb_lipsi_prog_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lipsi_prog_loader_if.sv
// lipsi_prog_loader_if: valid/ready byte stream feeding the program loader
interface lipsi_prog_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/lipsi_prog_loader.sv
// lipsi_prog_loader: loads a LEN/payload/CHK frame into imem, appends 0xFF, releases cpu reset (optional LOADER_TIMEOUT_EN)
module lipsi_prog_loader #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  lipsi_prog_loader_if.slave s,
  input  logic reload,
  output logic imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic cpu_reset,
  output logic load_done,
  output logic load_err,
  output logic [1:0] err_code
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, TERM, RUN, ERROR} state_t;
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end
  state_t state, state_n;
  logic [7:0] len, count, sum, len_n, count_n, sum_n, addr_n, wdata_n;
  logic we_n, cpu_reset_n, load_done_n, load_err_n, acc;
  logic [1:0] err_code_n;
  assign acc = s.in_valid && s.in_ready;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr, tmr_n;
`endif
  // next-state and next-output decode for the frame parser
  always_comb begin
    state_n = state;
    len_n = len;
    count_n = count;
    sum_n = sum;
    we_n = 1'b0;
    addr_n = imem_addr;
    wdata_n = imem_wdata;
    cpu_reset_n = cpu_reset;
    load_done_n = load_done;
    load_err_n = load_err;
    err_code_n = err_code;
    case (state)
      IDLE: if (acc) begin
        if (s.in_data == 8'd0) begin
          state_n = ERROR;
          load_err_n = 1'b1;
          err_code_n = 2'b01;
        end else begin
          state_n = LOAD;
          len_n = s.in_data;
          count_n = 8'd0;
          sum_n = 8'd0;
        end
      end
      LOAD: if (acc) begin
        we_n = 1'b1;
        addr_n = count;
        wdata_n = s.in_data;
        sum_n = sum + s.in_data;
        count_n = count + 8'd1;
        state_n = (count == len - 8'd1) ? CHECK : LOAD;
      end
      CHECK: if (acc) begin
        if (s.in_data == sum) begin
          state_n = TERM;
          we_n = 1'b1;
          addr_n = len;
          wdata_n = 8'hFF;
        end else begin
          state_n = ERROR;
          load_err_n = 1'b1;
          err_code_n = 2'b10;
        end
      end
      TERM: begin
        state_n = RUN;
        cpu_reset_n = 1'b0;
        load_done_n = 1'b1;
      end
      RUN: if (reload) begin
        state_n = IDLE;
        cpu_reset_n = 1'b1;
        load_done_n = 1'b0;
      end
      ERROR: if (reload) begin
        state_n = IDLE;
        load_err_n = 1'b0;
        err_code_n = 2'b00;
      end
      default: state_n = IDLE;
    endcase
`ifdef LOADER_TIMEOUT_EN
    tmr_n = (acc || !(state == LOAD || state == CHECK)) ? '0 : tmr + 1'b1;
    if (!acc && (state == LOAD || state == CHECK) && tmr == TW'(TIMEOUT_CYC - 1)) begin
      state_n = ERROR;
      we_n = 1'b0;
      load_err_n = 1'b1;
      err_code_n = 2'b11;
      tmr_n = '0;
    end
`endif
  end
  // state and registered outputs; in_ready decodes the state being entered so it stays low during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len <= 8'd0;
      count <= 8'd0;
      sum <= 8'd0;
      imem_we <= 1'b0;
      imem_addr <= 8'd0;
      imem_wdata <= 8'd0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
      err_code <= 2'b00;
      s.in_ready <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      count <= count_n;
      sum <= sum_n;
      imem_we <= we_n;
      imem_addr <= addr_n;
      imem_wdata <= wdata_n;
      cpu_reset <= cpu_reset_n;
      load_done <= load_done_n;
      load_err <= load_err_n;
      err_code <= err_code_n;
      s.in_ready <= (state_n == IDLE) || (state_n == LOAD) || (state_n == CHECK);
    end
  end
`ifdef LOADER_TIMEOUT_EN
  // idle-cycle counter between accepted bytes
  always_ff @(posedge clk) begin
    if (reset) tmr <= '0;
    else tmr <= tmr_n;
  end
`endif
endmodule

// File: tb/tb_lipsi_prog_loader.sv
// tb_lipsi_prog_loader: randomized frames checked every cycle against a frame-level model (LOADER_TIMEOUT_EN adds a stall test)
module tb_lipsi_prog_loader;
  localparam int TO = `ifdef LOADER_TIMEOUT_EN 16 `else 1000 `endif;
  localparam int P_IDLE = 0, P_PAY = 1, P_CHK = 2, P_TERM = 3, P_RUN = 4, P_ERR = 5;
  typedef struct {
    int c;
    bit w;
    logic [7:0] a, d;
    bit rdy, cr, dn, er;
    logic [1:0] code;
  } snap_t;
  logic clk = 1'b0, reset = 1'b1, reload = 1'b0;
  logic imem_we, cpu_reset, load_done, load_err;
  logic [7:0] imem_addr, imem_wdata;
  logic [1:0] err_code;
  lipsi_prog_loader_if bus();
  lipsi_prog_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .s(bus), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  snap_t q[$];
  logic [15:0] wlog[$];
  int phase = P_IDLE, m_len = 0, m_idx = 0, m_tmo = 0;
  logic [7:0] m_sum = 0, m_a = 0, m_d = 0;
  bit m_rdy = 0, m_cr = 1, m_dn = 0, m_er = 0, m_post = 0;
  logic [1:0] m_code = 0;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask
  function automatic void push(input int n, input bit w);
    snap_t s;
    s.c = n; s.w = w; s.a = m_a; s.d = m_d;
    s.rdy = m_rdy; s.cr = m_cr; s.dn = m_dn; s.er = m_er; s.code = m_code;
    q.push_back(s);
  endfunction
  task automatic model_edge(input int n, input logic v, input logic [7:0] d, input logic rl, input logic rs);
    bit acc;
    int pb;
    if (rs) begin
      phase = P_IDLE; m_a = 0; m_d = 0; m_rdy = 0; m_cr = 1; m_dn = 0; m_er = 0; m_code = 0;
      m_post = 1; m_tmo = 0;
      push(n, 0);
      return;
    end
    if (m_post) begin
      m_post = 0; m_rdy = 1;
      push(n, 0);
      return;
    end
    acc = v && m_rdy;
    pb = phase;
    case (phase)
      P_IDLE: if (acc) begin
        if (d == 0) begin
          phase = P_ERR; m_rdy = 0; m_er = 1; m_code = 1; push(n, 0);
        end else begin
          m_len = d; m_idx = 0; m_sum = 0; phase = P_PAY;
        end
      end
      P_PAY: if (acc) begin
        m_a = 8'(m_idx); m_d = d; m_sum = m_sum + d; m_idx++;
        if (m_idx == m_len) phase = P_CHK;
        push(n, 1);
      end
      P_CHK: if (acc) begin
        if (d == m_sum) begin
          m_a = 8'(m_len); m_d = 8'hFF; m_rdy = 0; phase = P_TERM; push(n, 1);
        end else begin
          m_rdy = 0; m_er = 1; m_code = 2; phase = P_ERR; push(n, 0);
        end
      end
      P_TERM: begin
        m_cr = 0; m_dn = 1; phase = P_RUN; push(n, 0);
      end
      P_RUN: if (rl) begin
        m_cr = 1; m_dn = 0; m_rdy = 1; phase = P_IDLE; push(n, 0);
      end
      P_ERR: if (rl) begin
        m_er = 0; m_code = 0; m_rdy = 1; phase = P_IDLE; push(n, 0);
      end
      default: ;
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (pb == P_PAY || pb == P_CHK) begin
      if (acc) m_tmo = 0;
      else if (++m_tmo == TO) begin
        phase = P_ERR; m_rdy = 0; m_er = 1; m_code = 3; m_tmo = 0; push(n, 0);
      end
    end else m_tmo = 0;
`else
    if (pb < 0) m_tmo = 0;
`endif
  endtask
  task automatic tick(input logic v, input logic [7:0] d, input logic rl, input logic rs);
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; reload = rl; reset = rs;
    model_edge(cyc + 1, v, d, rl, rs);
  endtask
  task automatic idle(input int k);
    repeat (k) tick(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
  endtask
  function automatic int rgap();
    return $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
  endfunction
  snap_t cur;
  bit live = 0;
  // per-cycle comparison of every output against the model's expected snapshot
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
    if (q.size() > 0 && q[0].c == cyc) begin
      cur = q.pop_front();
      live = 1;
    end else cur.w = 0;
    if (live) begin
      chk("imem_we", 8'(imem_we), 8'(cur.w));
      chk("imem_addr", imem_addr, cur.a);
      chk("imem_wdata", imem_wdata, cur.d);
      chk("in_ready", 8'(bus.in_ready), 8'(cur.rdy));
      chk("cpu_reset", 8'(cpu_reset), 8'(cur.cr));
      chk("load_done", 8'(load_done), 8'(cur.dn));
      chk("load_err", 8'(load_err), 8'(cur.er));
      chk("err_code", 8'(err_code), 8'(cur.code));
      if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});
    end
  end
  initial begin
    logic [7:0] b, s;
    int len, kind, cut;
    bus.in_valid = 0; bus.in_data = 0;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_in_ready", 8'(bus.in_ready), 8'h0);
    chk("rst_cpu_reset", 8'(cpu_reset), 8'h1);
    chk("rst_addr", imem_addr, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    // frame 03,C7,05,00,CC back-to-back
    wlog.delete();
    send(8'h03, 0); send(8'hC7, 0); send(8'h05, 0); send(8'h00, 0); send(8'hCC, 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_term_we", 8'(imem_we), 8'h1);
    chk("t1_term_addr", imem_addr, 8'h03);
    chk("t1_term_data", imem_wdata, 8'hFF);
    chk("t1_term_cpu_reset", 8'(cpu_reset), 8'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_cpu_reset", 8'(cpu_reset), 8'h0);
    chk("t1_load_done", 8'(load_done), 8'h1);
    chk("t1_err_code", 8'(err_code), 8'h0);
    idle(2);
    chk("t1_nwrites", 8'(wlog.size()), 8'd4);
    if (wlog.size() == 4) begin
      chk("t1_w0", wlog[0][7:0], 8'hC7); chk("t1_a1", wlog[1][15:8], 8'h01);
      chk("t1_w2", wlog[2][7:0], 8'h00); chk("t1_a3", wlog[3][15:8], 8'h03);
      chk("t1_w3", wlog[3][7:0], 8'hFF);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    // bad checksum
    wlog.delete();
    send(8'h02, 0); send(8'h10, 0); send(8'h20, 0); send(8'h31, 0);
    idle(3);
    chk("t2_load_err", 8'(load_err), 8'h1);
    chk("t2_err_code", 8'(err_code), 8'h2);
    chk("t2_cpu_reset", 8'(cpu_reset), 8'h1);
    chk("t2_nwrites", 8'(wlog.size()), 8'd2);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    // LEN == 0
    send(8'h00, 0);
    idle(1);
    chk("t3_err_code", 8'(err_code), 8'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk("t3_load_err", 8'(load_err), 8'h0);
    chk("t3_in_ready", 8'(bus.in_ready), 8'h1);
    // gapped frame with wrapping sum, then reload and a new frame
    send(8'h02, 3); send(8'hAA, 3); send(8'hAB, 3); send(8'h55, 3);
    idle(3);
    chk("t4_load_done", 8'(load_done), 8'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk("t4_reload_cpu_reset", 8'(cpu_reset), 8'h1);
    chk("t4_reload_done", 8'(load_done), 8'h0);
    send(8'h01, 0); send(8'h7E, 0); send(8'h7E, 0);
    idle(3);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    // reset mid-load, then a fresh frame
    send(8'h05, 0); send(8'h12, 0); send(8'h34, 0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_addr", imem_addr, 8'h00);
    chk("t5_wdata", imem_wdata, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h01, 1); send(8'hFF, 0); send(8'hFF, 0);
    idle(3);
    chk("t5_load_done", 8'(load_done), 8'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef LOADER_TIMEOUT_EN
    send(8'h04, 0); send(8'h11, 0);
    idle(17);
    chk("t6_err_code", 8'(err_code), 8'h3);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h02, 0); send(8'h01, 0);
    idle(15);
    send(8'h02, 0); send(8'h03, 0);
    idle(3);
    chk("t6_load_done", 8'(load_done), 8'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
`endif
    // randomized frames: good, LEN=255, LEN=0, bad checksum, reset mid-frame
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) send(8'h00, rgap());
      else begin
        len = (kind == 1) ? 255 : $urandom_range(1, 12);
        cut = (kind == 2) ? $urandom_range(0, len - 1) : len;
        send(8'(len), rgap());
        s = 0;
        for (int i = 0; i < cut; i++) begin
          b = 8'($urandom);
          s = s + b;
          send(b, rgap());
        end
        if (kind == 2) begin
          tick(1'b0, 8'h00, 1'b0, 1'b1);
          tick(1'b0, 8'h00, 1'b0, 1'b0);
        end else send(s + ((kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00), rgap());
      end
      idle($urandom_range(2, 4));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      idle(1);
    end
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
